// File: rtl/vec_pkg.sv
// Shared types and sizing for the vector execute stage.
package vec_pkg;
  localparam int LANE_W    = 16;
  localparam int NUM_LANES = 4;
  localparam int MUL_STEPS = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_XOR  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_SHL  = 3'b101,
    OP_ROTL = 3'b110,
    OP_MUL  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } exec_state_e;
endpackage

// File: rtl/vec_lane_alu.sv
// One vector lane: combinational single-cycle ALU plus, when VEC_EXEC_MUL_EN
// is defined, the radix-4 iterative multiply datapath for that lane.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int W = LANE_W
) (
`ifdef VEC_EXEC_MUL_EN
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_step,
`endif
  input  alu_op_e      i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_res
`ifdef VEC_EXEC_MUL_EN
  ,
  output logic [W-1:0] o_acc
`endif
);

  logic [3:0]     w_sh;
  logic [2*W-1:0] w_dbl;

  assign w_sh  = i_b[3:0];
  // Rotate by shifting a doubled copy; the upper half holds the wrapped bits.
  assign w_dbl = {i_a, i_a} << w_sh;

  always_comb begin
    o_res = '0;
    unique case (i_op)
      OP_ADD:  o_res = i_a + i_b;
      OP_SUB:  o_res = i_a - i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_SHL:  o_res = i_a << w_sh;
      OP_ROTL: o_res = w_dbl[2*W-1:W];
      default: o_res = '0;
    endcase
  end

`ifdef VEC_EXEC_MUL_EN
  logic [W-1:0] r_acc, r_mcand, r_mplier;
  logic [W-1:0] w_pp;

  always_comb begin
    w_pp = '0;
    unique case (r_mplier[1:0])
      2'd0:    w_pp = '0;
      2'd1:    w_pp = r_mcand;
      2'd2:    w_pp = r_mcand << 1;
      default: w_pp = r_mcand + (r_mcand << 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (i_step) begin
      r_acc    <= r_acc + w_pp;
      r_mcand  <= r_mcand << 2;
      r_mplier <= r_mplier >> 2;
    end
  end

  assign o_acc = r_acc;
`endif

endmodule

// File: rtl/vector_execute.sv
// Execute stage of the 4-lane vector pipeline with EX/MEM registers.
// VEC_EXEC_MUL_EN builds the iterative multiplier, its FSM and stallE.
module vector_execute #(
  parameter int LANES = vec_pkg::NUM_LANES,
  parameter int W     = vec_pkg::LANE_W
`ifdef VEC_EXEC_MUL_EN
  ,
  parameter int MUL_STEPS = vec_pkg::MUL_STEPS
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  RD01E,
  input  logic [W-1:0]  RD11E,
  input  logic [W-1:0]  RD21E,
  input  logic [W-1:0]  RD31E,
  input  logic [W-1:0]  RD02E,
  input  logic [W-1:0]  RD12E,
  input  logic [W-1:0]  RD22E,
  input  logic [W-1:0]  RD32E,
  input  logic [3:0]    RdE,
  input  logic          regWriteE,
  input  logic          memWriteE,
  input  logic          branchE,
  input  logic          resultSrcE,
  input  logic [2:0]    aluControlE,
  input  logic          validE,
  input  logic          flushE,
  output logic [W-1:0]  ALUResM0,
  output logic [W-1:0]  ALUResM1,
  output logic [W-1:0]  ALUResM2,
  output logic [W-1:0]  ALUResM3,
  output logic [W-1:0]  writeDataM0,
  output logic [W-1:0]  writeDataM1,
  output logic [W-1:0]  writeDataM2,
  output logic [W-1:0]  writeDataM3,
  output logic [3:0]    RdM,
  output logic          regWriteM,
  output logic          memWriteM,
  output logic          resultSrcM,
  output logic          validM,
  output logic          stallE,
  output logic          branchTakenE
);
  import vec_pkg::*;

  alu_op_e                     w_op;
  logic [LANES-1:0][W-1:0]     w_a, w_b, w_res, w_mres;
  logic                        w_stall, w_mvalid;

  logic [LANES-1:0][W-1:0]     r_res, r_wd;
  logic [3:0]                  r_rd;
  logic                        r_regw, r_memw, r_rsrc, r_valid;

  assign w_op = alu_op_e'(aluControlE);
  assign w_a  = {RD31E, RD21E, RD11E, RD01E};
  assign w_b  = {RD32E, RD22E, RD12E, RD02E};

  assign branchTakenE = validE & branchE & ~flushE & (RD01E == RD02E);

`ifdef VEC_EXEC_MUL_EN
  localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

  exec_state_e             r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic                    w_load, w_step;
  logic [LANES-1:0][W-1:0] w_acc;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_stall     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (validE && (w_op == OP_MUL) && !flushE) begin
          w_state_nxt = S_MUL;
          w_load      = 1'b1;
          w_stall     = 1'b1;
        end
      end
      S_MUL: begin
        w_stall = 1'b1;
        if (flushE) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == CW'(MUL_STEPS - 1)) w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load)      r_cnt <= '0;
      else if (w_step) r_cnt <= r_cnt + 1'b1;
    end
  end

  // DONE commits the accumulators; otherwise M takes the single-cycle result.
  assign w_mres = (r_state == S_DONE) ? w_acc : w_res;
`else
  assign w_stall = 1'b0;
  assign w_mres  = w_res;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vec_lane_alu #(.W(W)) u_lane (
`ifdef VEC_EXEC_MUL_EN
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_step (w_step),
      .o_acc  (w_acc[l]),
`endif
      .i_op   (w_op),
      .i_a    (w_a[l]),
      .i_b    (w_b[l]),
      .o_res  (w_res[l])
    );
  end

  assign stallE   = w_stall;
  assign w_mvalid = validE & ~flushE & ~w_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_res   <= '0;
      r_wd    <= '0;
      r_rd    <= '0;
      r_regw  <= 1'b0;
      r_memw  <= 1'b0;
      r_rsrc  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_res   <= w_mres;
      r_wd    <= w_b;
      r_rd    <= RdE;
      r_regw  <= regWriteE & w_mvalid;
      r_memw  <= memWriteE & w_mvalid;
      r_rsrc  <= resultSrcE;
      r_valid <= w_mvalid;
    end
  end

  assign ALUResM0    = r_res[0];
  assign ALUResM1    = r_res[1];
  assign ALUResM2    = r_res[2];
  assign ALUResM3    = r_res[3];
  assign writeDataM0 = r_wd[0];
  assign writeDataM1 = r_wd[1];
  assign writeDataM2 = r_wd[2];
  assign writeDataM3 = r_wd[3];
  assign RdM         = r_rd;
  assign regWriteM   = r_regw;
  assign memWriteM   = r_memw;
  assign resultSrcM  = r_rsrc;
  assign validM      = r_valid;

endmodule

// File: tb/tb_vector_execute.sv
// Directed bench for vector_execute; multiply checks follow VEC_EXEC_MUL_EN.
module tb_vector_execute;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] RD01E, RD11E, RD21E, RD31E, RD02E, RD12E, RD22E, RD32E;
  logic [3:0]  RdE;
  logic        regWriteE, memWriteE, branchE, resultSrcE, validE, flushE;
  logic [2:0]  aluControlE;
  logic [15:0] ALUResM0, ALUResM1, ALUResM2, ALUResM3;
  logic [15:0] writeDataM0, writeDataM1, writeDataM2, writeDataM3;
  logic [3:0]  RdM;
  logic        regWriteM, memWriteM, resultSrcM, validM, stallE, branchTakenE;

  int checks   = 0;
  int failures = 0;

  vector_execute dut (
    .clk(clk), .rst(rst),
    .RD01E(RD01E), .RD11E(RD11E), .RD21E(RD21E), .RD31E(RD31E),
    .RD02E(RD02E), .RD12E(RD12E), .RD22E(RD22E), .RD32E(RD32E),
    .RdE(RdE), .regWriteE(regWriteE), .memWriteE(memWriteE),
    .branchE(branchE), .resultSrcE(resultSrcE), .aluControlE(aluControlE),
    .validE(validE), .flushE(flushE),
    .ALUResM0(ALUResM0), .ALUResM1(ALUResM1), .ALUResM2(ALUResM2), .ALUResM3(ALUResM3),
    .writeDataM0(writeDataM0), .writeDataM1(writeDataM1),
    .writeDataM2(writeDataM2), .writeDataM3(writeDataM3),
    .RdM(RdM), .regWriteM(regWriteM), .memWriteM(memWriteM),
    .resultSrcM(resultSrcM), .validM(validM),
    .stallE(stallE), .branchTakenE(branchTakenE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lanes(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
    RD01E = a0; RD11E = a1; RD21E = a2; RD31E = a3;
    RD02E = b0; RD12E = b1; RD22E = b2; RD32E = b3;
  endtask

  task automatic res4(input string tag, input logic [15:0] e0, e1, e2, e3);
    chk({tag, "_l0"}, ALUResM0, e0);
    chk({tag, "_l1"}, ALUResM1, e1);
    chk({tag, "_l2"}, ALUResM2, e2);
    chk({tag, "_l3"}, ALUResM3, e3);
  endtask

`ifdef VEC_EXEC_MUL_EN
  // Counts stall cycles from the current cycle and bubbles loaded meanwhile;
  // leaves the bench in the DONE cycle.
  task automatic run_mul(input string tag);
    int cyc = 0, bad = 0;
    while (stallE === 1'b1 && cyc < 30) begin
      cyc++;
      tick();
      if (validM !== 1'b0 || regWriteM !== 1'b0) bad++;
    end
    chk({tag, "_stall_cycles"}, 16'(cyc), 16'd9);
    chk({tag, "_bubbles"}, 16'(bad), 16'd0);
  endtask
`endif

  initial begin
    rst = 1'b0; validE = 1'b1; flushE = 1'b0; branchE = 1'b0;
    regWriteE = 1'b1; memWriteE = 1'b1; resultSrcE = 1'b1;
    aluControlE = 3'b000; RdE = 4'd7;
    lanes(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1, 16'h1, 16'h1, 16'h1);

    // Reset held two cycles with a valid instruction present
    tick(); tick();
    res4("rst_res", 16'h0, 16'h0, 16'h0, 16'h0);
    chk("rst_wd0", writeDataM0, 16'h0);
    chk("rst_wd3", writeDataM3, 16'h0);
    chk("rst_rd", {12'h0, RdM}, 16'h0);
    chk("rst_ctl", {12'h0, regWriteM, memWriteM, resultSrcM, validM}, 16'h0);
    chk("rst_stall", {15'h0, stallE}, 16'h0);

    // Add across lanes
    rst = 1'b1; memWriteE = 1'b0; resultSrcE = 1'b0; RdE = 4'd3;
    lanes(16'hFFFF, 16'h0001, 16'h1234, 16'h8000, 16'h0001, 16'h0001, 16'h1111, 16'h8000);
    tick();
    res4("add", 16'h0000, 16'h0002, 16'h2345, 16'h0000);
    chk("add_rd", {12'h0, RdM}, 16'd3);
    chk("add_ctl", {12'h0, regWriteM, memWriteM, resultSrcM, validM}, 16'b1001);
    chk("add_wd2", writeDataM2, 16'h1111);

    // Sub wraps modulo 2^16
    aluControlE = 3'b001;
    lanes(16'h0000, 16'h0005, 16'h8000, 16'h1234, 16'h0001, 16'h0003, 16'h0001, 16'h1234);
    tick();
    res4("sub", 16'hFFFF, 16'h0002, 16'h7FFF, 16'h0000);

    // Rotate left, including shift amount 0
    aluControlE = 3'b110; memWriteE = 1'b1;
    lanes(16'h8001, 16'h1234, 16'h00FF, 16'hF000, 16'h0001, 16'h0000, 16'h0004, 16'h0004);
    tick();
    res4("rotl", 16'h0003, 16'h1234, 16'h0FF0, 16'h000F);
    chk("rotl_memw", {15'h0, memWriteM}, 16'h1);

    // Shift left on the same operands drops the outgoing bits
    aluControlE = 3'b101; memWriteE = 1'b0;
    tick();
    res4("shl", 16'h0002, 16'h1234, 16'h0FF0, 16'h0000);

    // Logic ops on lane 0
    lanes(16'hFF00, 16'h0, 16'h0, 16'h0, 16'h0FF0, 16'h0, 16'h0, 16'h0);
    aluControlE = 3'b010; tick(); chk("xor", ALUResM0, 16'hF0F0);
    aluControlE = 3'b011; tick(); chk("and", ALUResM0, 16'h0F00);
    aluControlE = 3'b100; tick(); chk("or",  ALUResM0, 16'hFFF0);

    // Invalid slot loads a bubble
    validE = 1'b0; tick();
    chk("inv_ctl", {12'h0, regWriteM, memWriteM, 1'b0, validM}, 16'h0);

    // Branch resolution on lane 0
    validE = 1'b1; branchE = 1'b1; regWriteE = 1'b0; aluControlE = 3'b001;
    lanes(16'hABCD, 16'h0, 16'h0, 16'h0, 16'hABCD, 16'h1, 16'h1, 16'h1);
    #1 chk("br_eq", {15'h0, branchTakenE}, 16'h1);
    RD02E = 16'hABCE;
    #1 chk("br_ne", {15'h0, branchTakenE}, 16'h0);
    RD02E = 16'hABCD; flushE = 1'b1;
    #1 chk("br_flush", {15'h0, branchTakenE}, 16'h0);

    // Flush in IDLE produces a bubble
    branchE = 1'b0; regWriteE = 1'b1; memWriteE = 1'b1; aluControlE = 3'b000;
    tick();
    chk("flush_ctl", {12'h0, regWriteM, memWriteM, 1'b0, validM}, 16'h0);
    memWriteE = 1'b0;

`ifdef VEC_EXEC_MUL_EN
    // Flush beats a simultaneous multiply start
    aluControlE = 3'b111;
    #1 chk("mul_flush_nostall", {15'h0, stallE}, 16'h0);
    flushE = 1'b0;

    // Multiply 3*5 on lanes 0-2, 0x1234*0x5678 on lane 3
    lanes(16'h3, 16'h3, 16'h3, 16'h1234, 16'h5, 16'h5, 16'h5, 16'h5678);
    RdE = 4'd9;
    #1 chk("mul_start_stall", {15'h0, stallE}, 16'h1);
    run_mul("mul1");
    tick();
    res4("mul1", 16'h000F, 16'h000F, 16'h000F, 16'h0060);
    chk("mul1_ctl", {12'h0, regWriteM, memWriteM, 1'b0, validM}, 16'b1001);
    chk("mul1_rd", {12'h0, RdM}, 16'd9);

    // Back-to-back multiply starts right after DONE
    lanes(16'h7, 16'hFFFF, 16'h0100, 16'h0, 16'h9, 16'hFFFF, 16'h0100, 16'h1234);
    #1 chk("mul2_start_stall", {15'h0, stallE}, 16'h1);
    run_mul("mul2");
    tick();
    res4("mul2", 16'h003F, 16'h0001, 16'h0000, 16'h0000);
    validE = 1'b0;
    #1 chk("mul2_idle_stall", {15'h0, stallE}, 16'h0);

    // Abort by flush at counter 3
    validE = 1'b1;
    lanes(16'h3, 16'h3, 16'h3, 16'h3, 16'h5, 16'h5, 16'h5, 16'h5);
    tick(); tick(); tick(); tick();
    chk("abort_mid_stall", {15'h0, stallE}, 16'h1);
    flushE = 1'b1;
    tick();
    flushE = 1'b0; validE = 1'b0;
    #1 chk("abort_stall", {15'h0, stallE}, 16'h0);
    chk("abort_validM", {15'h0, validM}, 16'h0);
    validE = 1'b1; aluControlE = 3'b000;
    tick();
    chk("abort_next_add", ALUResM0, 16'h0008);
    chk("abort_next_valid", {15'h0, validM}, 16'h1);

    // Abort by reset mid-multiply
    aluControlE = 3'b111;
    tick(); tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; validE = 1'b0;
    res4("rstabort", 16'h0, 16'h0, 16'h0, 16'h0);
    chk("rstabort_ctl", {12'h0, regWriteM, memWriteM, resultSrcM, validM}, 16'h0);
    chk("rstabort_rd", {12'h0, RdM}, 16'h0);
    #1 chk("rstabort_stall", {15'h0, stallE}, 16'h0);
`else
    // Without the multiplier, op 111 is a single-cycle zero
    flushE = 1'b0; aluControlE = 3'b111;
    lanes(16'h3, 16'h3, 16'h3, 16'h1234, 16'h5, 16'h5, 16'h5, 16'h5678);
    #1 chk("mul_nostall", {15'h0, stallE}, 16'h0);
    tick();
    res4("mul_zero", 16'h0, 16'h0, 16'h0, 16'h0);
    chk("mul_zero_valid", {15'h0, validM}, 16'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vector_execute.md
# vector_execute

Execute stage of the 4-lane, 16-bit vector encryption pipeline. It sits directly downstream of `decode` and consumes its ID/EX outputs: lane operands, destination register and control bits. It computes one ALU result per lane and resolves branches on lane 0. It registers everything into the EX/MEM boundary for the memory stage. Multiply runs as a multi-cycle iterative operation that stalls the front end.

## Interface
- `LANES`, 4: number of vector lanes; the port list is fixed at 4 lanes.
- `W`, 16: lane data width.
- `MUL_STEPS`, 8: radix-4 multiply iterations (W/2).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `RD01E`,`RD11E`,`RD21E`,`RD31E` in 16: lane 0..3 source operand A.
- `RD02E`,`RD12E`,`RD22E`,`RD32E` in 16: lane 0..3 source operand B; also store data.
- `RdE` in 4: destination register.
- `regWriteE`,`memWriteE`,`branchE`,`resultSrcE` in 1: control from decode.
- `aluControlE` in 3: operation select.
- `validE` in 1: the ID/EX slot holds a real instruction.
- `flushE` in 1: kill the instruction in EX (from the hazard unit).
- `ALUResM0..3` out 16: registered lane results.
- `writeDataM0..3` out 16: registered operand B per lane.
- `RdM` out 4, `regWriteM`,`memWriteM`,`resultSrcM`,`validM` out 1: registered control.
- `stallE` out 1: decode and fetch must hold their state.
- `branchTakenE` out 1: combinational branch decision.

## Operation
- aluControl encodings:
  - 000 add, 001 sub, 010 xor, 011 and, 100 or.
  - 101 shl by B[3:0]; 110 rotl by B[3:0].
  - 111 mul: low 16 bits of A*B.
- All arithmetic is modulo 2^16. Carries are discarded and there are no flags.
- Shift or rotate by 0 returns A unchanged.
- Branch: `branchTakenE = validE & branchE & ~flushE & (RD01E == RD02E)`. Lanes 1-3 are ignored for branch resolution.
- FSM states: IDLE, MUL, DONE.
  - IDLE → MUL when `validE & aluControlE==111 & ~flushE`. Multiplier, multiplicand and accumulator are loaded for all lanes, and the counter is cleared to 0.
  - MUL: each cycle adds a (B[1:0] × A) partial product per lane, shifts A left by 2 and B right by 2, and increments the counter. MUL → DONE after the counter reaches `MUL_STEPS-1`.
  - DONE → IDLE on the next edge; the accumulators are written into the M registers.
- `stallE = (IDLE & validE & mul & ~flushE) | MUL`. It is low in DONE.
- Decode holds its inputs stable while `stallE` is high.
- Every edge with `stallE` high loads a bubble into M: `validM`, `regWriteM` and `memWriteM` are 0.
- For a bubble or any `validE=0` edge, `regWriteM`, `memWriteM` and `validM` are 0. The data registers may hold any value.
- `flushE`:
  - In IDLE, the next M is a bubble.
  - In MUL or DONE, the multiply is aborted, the state returns to IDLE and the next M is a bubble.
  - `flushE` wins over a simultaneous multiply start.
- Reset (rst=0) at any point returns the FSM to IDLE, clears the counter and zeroes every M output. An in-flight multiply is lost.

## Timing
- Single-cycle ops: operands valid before edge N; results appear on the M outputs after edge N.
- Multiply:
  - Start edge S (IDLE→MUL).
  - Edges S+1..S+8 are the iterations; the final one takes MUL→DONE.
  - Edge S+9 loads M (DONE→IDLE).
  - `stallE` is high from the start cycle through the last MUL cycle, i.e. 9 cycles. The result is visible after edge S+9.
- Back-to-back multiply: a second multiply presented in the cycle after DONE starts normally. No idle gap is required beyond DONE.
- `branchTakenE` is combinational and valid in the same cycle as the inputs. It is never asserted while `stallE` is high from MUL, because a branch cannot be a multiply.
- All M outputs reset to 0.

## Configuration
- `VEC_EXEC_MUL_EN` defined: the iterative multiplier, the MUL/DONE states and the `stallE` logic are built.
- `VEC_EXEC_MUL_EN` undefined:
  - aluControl 111 is a single-cycle op returning 0 on every lane.
  - `stallE` is tied to 0, and the FSM and counter are removed.
  - All other ops are unchanged.

## Structure
- Package `vec_pkg` holds:
  - the `alu_op_e` enum (3 bits, encodings above);
  - the `exec_state_e` enum;
  - the constants `LANE_W=16`, `NUM_LANES=4` and `MUL_STEPS=8`.
- Sub-module `vec_lane_alu`: the combinational single-cycle ALU plus one lane's multiply datapath (accumulator, shift registers). Instantiated 4 times.
- The FSM, the counter and the EX/MEM registers live in `vector_execute`.

## Test plan
- Reset: hold rst=0 for 2 cycles with `validE=1` → all M outputs are 0 and `stallE=0`.
- Add across lanes:
  - Stimulus: A=FFFF/0001/1234/8000, B=0001/0001/1111/8000, op 000, `regWriteE=1`, `RdE=3`.
  - Response after one edge: ALURes=0000/0002/2345/0000, `RdM=3`, `regWriteM=1`, `validM=1`.
- rotl:
  - Lane 0: A=8001, B=0001 → 0003.
  - Lane 1: B=0000 → A unchanged.
  - shl lane 2: A=00FF, B=0004 → 0FF0.
- Multiply:
  - Stimulus: A=0003, B=0005 on all lanes, op 111.
  - Response: `stallE` high for exactly 9 cycles and bubbles in M. ALURes=000F after edge S+9.
  - Also check lane A=1234, B=5678 → 0060.
- Branch:
  - `branchE=1`, RD01E=RD02E=ABCD → `branchTakenE=1`.
  - RD02E=ABCE → 0.
  - With `flushE=1` → 0.
- Abort:
  - `flushE` at MUL counter=3 → the next edge is IDLE, `stallE=0`, `validM=0`.
  - Repeat with rst=0 in place of `flushE` → all M outputs are 0.
